uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
UART transmit path: the TX-side counterpart of the oversampled RX chain. Accepts a parallel word on a single-cycle valid strobe and serializes it as a frame: start bit, data LSB-first, optional even/odd parity, then stop bit. Each bit is held for Prescale CLK cycles, so TX and RX share one clock and one Prescale setting. Sits between the system-side data source and the TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9)

Ports:
CLK  input  1  system/oversampling clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
P_DATA  input  DATA_WIDTH  parallel data word; sampled only when a frame is accepted
Data_Valid  input  1  request to send P_DATA; sampled each rising edge
PAR_EN  input  1  1 = insert parity bit; latched at accept
PAR_TYP  input  1  0 = even, 1 = odd parity; latched at accept
Prescale  input  6  CLK cycles per bit; latched at accept; 0 treated as 1
TX_OUT  output  1  serial line, registered, idles high
Busy  output  1  registered; high while a frame is on the line

Behaviour:
- Reset (async, RST=0): state=IDLE, TX_OUT=1, Busy=0, counters cleared, latched data cleared; applies immediately, mid-frame included (frame aborted, line returns high).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: Data_Valid=1 at a rising edge while in IDLE, or during the final CLK cycle of STOP. Latch P_DATA, PAR_EN, PAR_TYP and Prescale. Compute parity from the latched data: XOR-reduce, inverted when PAR_TYP=1. Data_Valid at any other time is ignored.
- Latency: in the cycle after acceptance, TX_OUT=0 (START) and Busy=1.
- Bit timing: an internal edge counter runs 1..P. P is the latched Prescale, with 0 mapped to 1. The state/bit advances when the counter equals P, and the counter then reloads to 1. Every bit lasts exactly P cycles.
- START: TX_OUT=0 for P cycles, then go to DATA.
- DATA: TX_OUT = data[bit_idx], with bit_idx starting at 0 (LSB first). bit_idx increments every P cycles. After bit DATA_WIDTH-1, go to PARITY if PAR_EN=1, else STOP.
- PARITY: TX_OUT = parity bit for P cycles, then go to STOP.
- STOP: TX_OUT=1 for P cycles. On the last cycle:
  - if Data_Valid=1, accept and go directly to START. There is no idle gap, and Busy stays 1.
  - otherwise go to IDLE, and Busy=0 from the next cycle.
- Frame length: (2 + DATA_WIDTH + PAR_EN) * P cycles. Busy is high for exactly that many cycles per frame.
- Input changes to P_DATA, PAR_EN, PAR_TYP or Prescale during a frame have no effect on that frame.
- TX_OUT and Busy are glitch-free register outputs; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: RST pulse, Data_Valid=0 for 20 cycles -> TX_OUT=1, Busy=0 throughout.
- P=1, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> starting the next cycle, TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (parity=0). Busy high exactly 11 cycles, then TX_OUT=1, Busy=0.
- P=8, P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> each bit held 8 cycles, parity bit=0, frame 88 cycles. Repeat with PAR_TYP=0 -> parity bit=1. Repeat with Prescale=0 -> behaves as P=1, frame 11 cycles.
- Back-to-back, P=4, PAR_EN=0: 0x55 accepted, then Data_Valid=1 with 0xFF in the last STOP cycle -> START of the second frame immediately follows the stop bit. Busy stays high for 80 consecutive cycles. Data_Valid pulses mid-frame are ignored, with no extra frame sent.
- Reset mid-frame: P=2, assert RST=0 during data bit 3 -> TX_OUT=1 and Busy=0 immediately. After release, a new Data_Valid with 0x3C -> a complete, clean frame from START.
- Latching: change P_DATA, PAR_TYP and Prescale one cycle after accept -> transmitted frame matches the originally latched values bit-for-bit.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit.
// Each bit is held for Prescale clock cycles; back-to-back frames need no idle gap.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned PS_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PS_W-1:0]       r_cnt;
    logic [PS_W-1:0]       r_presc;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;

    logic [PS_W-1:0]       w_cnt_next;
    logic [PS_W-1:0]       w_presc_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_par_en_next;
    logic                  w_par_bit_next;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_last_data_bit;
    logic [PS_W-1:0]       w_presc_eff;

    // Bit boundary reached and frame-accept qualification
    assign w_last          = (r_cnt == r_presc);
    assign w_accept        = Data_Valid && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last));
    assign w_last_data_bit = (r_bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign w_presc_eff     = (Prescale == PS_W'(0)) ? PS_W'(1) : Prescale;

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last && w_last_data_bit) begin
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    w_state_next = w_accept ? S_START : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath next values: latch frame settings on accept, otherwise count bit time
    always_comb begin
        w_cnt_next     = r_cnt;
        w_presc_next   = r_presc;
        w_idx_next     = r_bit_idx;
        w_data_next    = r_data;
        w_par_en_next  = r_par_en;
        w_par_bit_next = r_par_bit;
        if (w_accept) begin
            w_cnt_next     = PS_W'(1);
            w_presc_next   = w_presc_eff;
            w_idx_next     = IDX_W'(0);
            w_data_next    = P_DATA;
            w_par_en_next  = PAR_EN;
            w_par_bit_next = (^P_DATA) ^ PAR_TYP;
        end else if (r_state != S_IDLE) begin
            if (w_last) begin
                w_cnt_next = PS_W'(1);
                if ((r_state == S_DATA) && !w_last_data_bit) begin
                    w_idx_next = r_bit_idx + IDX_W'(1);
                end
            end else begin
                w_cnt_next = r_cnt + PS_W'(1);
            end
        end
    end

    // Output decode from the upcoming state so the line is driven straight from flops
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_state_next != S_IDLE);
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_data_next[w_idx_next];
            S_PARITY: w_tx_next = w_par_bit_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= '0;
            r_presc   <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_presc   <= w_presc_next;
            r_bit_idx <= w_idx_next;
            r_data    <= w_data_next;
            r_par_en  <= w_par_en_next;
            r_par_bit <= w_par_bit_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
        end
    end

endmodule
